// File: rtl/stream_merge_rr_pkg.sv
// Shared types and helpers for the two-input round-robin stream merger.
package stream_merge_rr_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_t;

  typedef struct packed {
    src_t                 src;
    logic [WIDTH_DEF-1:0] bits;
  } entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_merge_queue.sv
// DEPTH-entry registered FIFO of {src, bits}; head read straight from storage.
module stream_merge_queue
  import stream_merge_rr_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_i,
  input  src_t             enq_src_i,
  input  logic [WIDTH-1:0] enq_bits_i,
  input  logic             deq_ready_i,
  output logic             space_o,
  output logic             head_valid_o,
  output src_t             head_src_o,
  output logic [WIDTH-1:0] head_bits_o,
  output logic [CW-1:0]    count_o
);

  typedef struct packed {
    src_t             src;
    logic [WIDTH-1:0] bits;
  } q_entry_t;

  q_entry_t          storage_q [DEPTH];
  q_entry_t          storage_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enq, deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    space_o      = (count_q < CW'(DEPTH));
    head_valid_o = (count_q != '0);
    head_src_o   = storage_q[rd_ptr_q].src;
    head_bits_o  = storage_q[rd_ptr_q].bits;
    count_o      = count_q;

    enq       = enq_i && space_o;
    deq       = head_valid_o && deq_ready_i;
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (enq) begin
      storage_d[wr_ptr_q] = '{src: enq_src_i, bits: enq_bits_i};
      wr_ptr_d            = next_ptr(wr_ptr_q);
    end
    if (deq) rd_ptr_d = next_ptr(rd_ptr_q);

    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      storage_q <= '{default: '0};
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      storage_q <= storage_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/stream_merge_rr.sv
// Two-to-one valid/ready merger: round-robin grant feeding a tagged output queue.
module stream_merge_rr
  import stream_merge_rr_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_in0_valid,
  output logic                        io_in0_ready,
  input  logic [WIDTH-1:0]            io_in0_bits,
  input  logic                        io_in1_valid,
  output logic                        io_in1_ready,
  input  logic [WIDTH-1:0]            io_in1_bits,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output logic [WIDTH-1:0]            io_out_bits,
  output logic                        io_out_src,
  output logic [clog2(DEPTH+1)-1:0]   io_count
);

  src_t             last_grant_q, last_grant_d;
  src_t             grant;
  src_t             head_src;
  logic             any_valid;
  logic             space;
  logic             enq;
  logic [WIDTH-1:0] enq_bits;

  // Readies use the registered space only, so io_out_ready never reaches them.
  always_comb begin
    any_valid = io_in0_valid || io_in1_valid;
    grant     = SRC0;
    if (io_in0_valid && io_in1_valid)
      grant = (last_grant_q == SRC0) ? SRC1 : SRC0;
    else if (io_in1_valid)
      grant = SRC1;

    io_in0_ready = space && any_valid && (grant == SRC0) && !reset;
    io_in1_ready = space && any_valid && (grant == SRC1) && !reset;

    enq          = (io_in0_valid && io_in0_ready) || (io_in1_valid && io_in1_ready);
    enq_bits     = (grant == SRC1) ? io_in1_bits : io_in0_bits;
    last_grant_d = enq ? grant : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= SRC1;
    else       last_grant_q <= last_grant_d;
  end

  stream_merge_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .enq_i        (enq),
    .enq_src_i    (grant),
    .enq_bits_i   (enq_bits),
    .deq_ready_i  (io_out_ready),
    .space_o      (space),
    .head_valid_o (io_out_valid),
    .head_src_o   (head_src),
    .head_bits_o  (io_out_bits),
    .count_o      (io_count)
  );

  assign io_out_src = head_src;

endmodule

// File: tb/tb_stream_merge_rr.sv
// Self-checking bench for stream_merge_rr: per-cycle vector table plus output scoreboard.
module tb_stream_merge_rr;
  import stream_merge_rr_pkg::*;

  logic       clk;
  logic       reset;
  logic       io_in0_valid, io_in0_ready;
  logic [7:0] io_in0_bits;
  logic       io_in1_valid, io_in1_ready;
  logic [7:0] io_in1_bits;
  logic       io_out_valid, io_out_ready;
  logic [7:0] io_out_bits;
  logic       io_out_src;
  logic [1:0] io_count;

  stream_merge_rr #(
    .WIDTH (8),
    .DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in0_valid (io_in0_valid),
    .io_in0_ready (io_in0_ready),
    .io_in0_bits  (io_in0_bits),
    .io_in1_valid (io_in1_valid),
    .io_in1_ready (io_in1_ready),
    .io_in1_bits  (io_in1_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_out_src   (io_out_src),
    .io_count     (io_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] b0;
    logic       v1;
    logic [7:0] b1;
    logic       ordy;
    logic       er0;
    logic       er1;
    logic       eov;
    logic [1:0] ecnt;
    logic       zchk;
  } vec_t;

  vec_t   vecs[$];
  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cur_vec  = -1;

  task automatic add(input logic rst, input logic v0, input logic [7:0] b0,
                     input logic v1, input logic [7:0] b1, input logic ordy,
                     input logic er0, input logic er1, input logic eov,
                     input logic [1:0] ecnt, input logic zchk);
    vec_t v;
    v = '{rst: rst, v0: v0, b0: b0, v1: v1, b1: b1, ordy: ordy,
          er0: er0, er1: er1, eov: eov, ecnt: ecnt, zchk: zchk};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (vector %0d)", name, act, exp, cur_vec);
    end
  endtask

  initial begin
    vec_t   v;
    entry_t e;

    // in0 only: 0x11, 0x22
    add(0, 1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 2'd0, 0);
    add(0, 1, 8'h22, 0, 8'h00, 1,  1, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 2'd0, 0);
    // reset, then continuous contention starting with in0
    add(1, 0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 2'd0, 0);
    add(0, 1, 8'hA0, 1, 8'hB0, 1,  1, 0, 0, 2'd0, 1);
    add(0, 1, 8'hA1, 1, 8'hB0, 1,  0, 1, 1, 2'd1, 0);
    add(0, 1, 8'hA1, 1, 8'hB1, 1,  1, 0, 1, 2'd1, 0);
    add(0, 1, 8'hA2, 1, 8'hB1, 1,  0, 1, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 2'd0, 0);
    // backpressure: 0x03 held while full, even during a dequeue cycle
    add(0, 1, 8'h01, 0, 8'h00, 0,  1, 0, 0, 2'd0, 0);
    add(0, 1, 8'h02, 0, 8'h00, 0,  1, 0, 1, 2'd1, 0);
    add(0, 1, 8'h03, 0, 8'h00, 0,  0, 0, 1, 2'd2, 0);
    add(0, 1, 8'h03, 0, 8'h00, 0,  0, 0, 1, 2'd2, 0);
    add(0, 1, 8'h03, 0, 8'h00, 1,  0, 0, 1, 2'd2, 0);
    add(0, 1, 8'h03, 0, 8'h00, 1,  1, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 2'd0, 0);
    // full with last_grant=0: blocked grant must not rotate; in1 wins after drain
    add(0, 1, 8'hC0, 0, 8'h00, 0,  1, 0, 0, 2'd0, 0);
    add(0, 1, 8'hC1, 0, 8'h00, 0,  1, 0, 1, 2'd1, 0);
    add(0, 1, 8'hC2, 1, 8'hD0, 0,  0, 0, 1, 2'd2, 0);
    add(0, 1, 8'hC2, 1, 8'hD0, 0,  0, 0, 1, 2'd2, 0);
    add(0, 1, 8'hC2, 1, 8'hD0, 1,  0, 0, 1, 2'd2, 0);
    add(0, 1, 8'hC2, 1, 8'hD0, 0,  0, 1, 1, 2'd1, 0);
    add(0, 1, 8'hC2, 1, 8'hD1, 1,  0, 0, 1, 2'd2, 0);
    add(0, 1, 8'hC2, 1, 8'hD1, 1,  1, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 2'd0, 0);
    // simultaneous enqueue/dequeue at count=1 across many pointer wraps
    add(0, 0, 8'h00, 1, 8'h50, 0,  0, 1, 0, 2'd0, 0);
    for (int unsigned i = 1; i <= 10; i++)
      add(0, 0, 8'h00, 1, 8'(8'h50 + i), 1,  0, 1, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 2'd0, 0);
    // reset with two beats queued: discarded, in0 wins next contention
    add(0, 1, 8'h60, 0, 8'h00, 0,  1, 0, 0, 2'd0, 0);
    add(0, 1, 8'h61, 0, 8'h00, 0,  1, 0, 1, 2'd1, 0);
    add(1, 1, 8'h62, 1, 8'h70, 1,  0, 0, 1, 2'd2, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 2'd0, 1);
    add(0, 1, 8'h80, 1, 8'h90, 1,  1, 0, 0, 2'd0, 1);
    add(0, 1, 8'h81, 1, 8'h90, 1,  0, 1, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 2'd1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 2'd0, 0);

    reset        = 1'b1;
    io_in0_valid = 1'b0;
    io_in0_bits  = '0;
    io_in1_valid = 1'b0;
    io_in1_bits  = '0;
    io_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_out_bits",  io_out_bits,  0);
    check("rst_out_src",   io_out_src,   0);
    check("rst_count",     io_count,     0);
    check("rst_in0_ready", io_in0_ready, 0);
    check("rst_in1_ready", io_in1_ready, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      v            = vecs[i];
      cur_vec      = i;
      reset        = v.rst;
      io_in0_valid = v.v0;
      io_in0_bits  = v.b0;
      io_in1_valid = v.v1;
      io_in1_bits  = v.b1;
      io_out_ready = v.ordy;
      if (v.er0) exp_q.push_back('{src: SRC0, bits: v.b0});
      if (v.er1) exp_q.push_back('{src: SRC1, bits: v.b1});

      @(negedge clk);
      check("in0_ready", io_in0_ready, v.er0);
      check("in1_ready", io_in1_ready, v.er1);
      check("out_valid", io_out_valid, v.eov);
      check("count",     io_count,     v.ecnt);
      if (v.zchk) begin
        check("zero_bits", io_out_bits, 0);
        check("zero_src",  io_out_src,  0);
      end

      if (v.rst) begin
        exp_q.delete();
      end else if (io_out_valid && io_out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sb_bits", io_out_bits, e.bits);
          check("sb_src",  io_out_src,  e.src);
        end
      end

      @(posedge clk);
      #1;
    end

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
